// File: rtl/button_event_ctrl.sv
// rtl/button_event_ctrl.sv - press/long-press event collector with round-robin serialiser
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   btn_clean  [N]    debounced button levels, synchronous to clk
//   ev_ready   consumer accepts the offered event
//   ev_valid   event offered
//   ev_idx     [IDXW] button index of the offered event
//   ev_long    0 = press event, 1 = long-press event
//   overrun    sticky, a new event merged into an already-pending one of the same kind

module button_event_ctrl #(
  parameter int N    = 5,
  parameter int IDXW = 3,
  parameter int HOLD = 100000000,
  parameter int CW   = 27
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    btn_clean,
  input  logic            ev_ready,
  output logic            ev_valid,
  output logic [IDXW-1:0] ev_idx,
  output logic            ev_long,
  output logic            overrun
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t          state, state_n;
  logic [N-1:0]    btn_prev, pend, lpend;
  logic [N-1:0]    rise, long_hit, req, clr_pend, clr_lpend;
  logic [CW-1:0]   hold_cnt [N];
  logic [IDXW-1:0] rr_last, rr_last_n, grant_idx, ev_idx_n;
  logic            ev_valid_n, ev_long_n, grant;

  assign rise = btn_clean & ~btn_prev;
  assign req  = pend | lpend;

  // Long event fires only on the HOLD-1 -> HOLD step, so a held button
  // raises it once; the saturated counter never matches again.
  always_comb begin
    long_hit = '0;
    for (int i = 0; i < N; i++) begin
      long_hit[i] = btn_clean[i] && (hold_cnt[i] == CW'(HOLD - 1));
    end
  end

  // Round-robin scan starting just after the last served index.
  always_comb begin
    int k;
    logic [IDXW-1:0] kk;
    grant     = 1'b0;
    grant_idx = '0;
    k         = 0;
    kk        = '0;
    for (int j = 0; j < N; j++) begin
      k  = (int'(rr_last) + 1 + j) % N;
      kk = IDXW'(k);
      if (!grant && req[kk]) begin
        grant     = 1'b1;
        grant_idx = kk;
      end
    end
  end

  always_comb begin
    state_n    = state;
    ev_valid_n = ev_valid;
    ev_idx_n   = ev_idx;
    ev_long_n  = ev_long;
    rr_last_n  = rr_last;
    clr_pend   = '0;
    clr_lpend  = '0;
    case (state)
      IDLE: begin
        if (grant) begin
          ev_idx_n   = grant_idx;
          // A pending press is always served before a long press of the same button.
          ev_long_n  = ~pend[grant_idx];
          if (pend[grant_idx]) clr_pend[grant_idx]  = 1'b1;
          else                 clr_lpend[grant_idx] = 1'b1;
          ev_valid_n = 1'b1;
          state_n    = OFFER;
        end
      end
      OFFER: begin
        if (ev_ready) begin
          ev_valid_n = 1'b0;
          rr_last_n  = ev_idx;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ev_valid <= 1'b0;
      ev_idx   <= '0;
      ev_long  <= 1'b0;
      rr_last  <= IDXW'(N - 1);
    end else begin
      state    <= state_n;
      ev_valid <= ev_valid_n;
      ev_idx   <= ev_idx_n;
      ev_long  <= ev_long_n;
      rr_last  <= rr_last_n;
    end
  end

  // Set terms are OR'd after the clear so a same-cycle new event survives a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev <= '0;
      pend     <= '0;
      lpend    <= '0;
      overrun  <= 1'b0;
      for (int i = 0; i < N; i++) hold_cnt[i] <= '0;
    end else begin
      btn_prev <= btn_clean;
      pend     <= (pend & ~clr_pend) | rise;
      lpend    <= (lpend & ~clr_lpend) | long_hit;
      overrun  <= overrun | (|(rise & pend & ~clr_pend)) | (|(long_hit & lpend & ~clr_lpend));
      for (int i = 0; i < N; i++) begin
        if (!btn_clean[i])                    hold_cnt[i] <= '0;
        else if (hold_cnt[i] != CW'(HOLD))    hold_cnt[i] <= hold_cnt[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// tb/tb_button_event_ctrl.sv - directed bench for button_event_ctrl (N=5, HOLD=8)

module tb_button_event_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn_clean = '0;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [2:0] ev_idx;
  logic       ev_long;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  // Accepted events encoded as cycle*100 + idx*10 + long.
  int ev_n;
  int ev_code [16];

  button_event_ctrl #(.N(5), .IDXW(3), .HOLD(8), .CW(4)) dut (
    .clk(clk), .rst(rst), .btn_clean(btn_clean), .ev_ready(ev_ready),
    .ev_valid(ev_valid), .ev_idx(ev_idx), .ev_long(ev_long), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic record(input int c);
    if (ev_valid && ev_ready && ev_n < 16) begin
      ev_code[ev_n] = c * 100 + int'(ev_idx) * 10 + int'(ev_long);
      ev_n++;
    end
  endtask

  task automatic test_reset();
    #2;
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ev_valid); end
    total++; if (ev_idx !== 3'd0)   begin bad++; $display("FAIL reset_idx: got %0d want 0", ev_idx); end
    total++; if (ev_long !== 1'b0)  begin bad++; $display("FAIL reset_long: got %b want 0", ev_long); end
    total++; if (overrun !== 1'b0)  begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(negedge clk);
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL idle_after_reset: got %b want 0", ev_valid); end
  endtask

  task automatic test_single_press();
    do_reset(); ev_ready = 1'b1; ev_n = 0;
    @(negedge clk); btn_clean = 5'b00100;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 3) btn_clean = '0;
      record(c);
    end
    total++; if (ev_n !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", ev_n); end
    total++; if (ev_code[0] !== 220) begin bad++; $display("FAIL single_event: got %0d want 220", ev_code[0]); end
  endtask

  task automatic test_simultaneous();
    do_reset(); ev_ready = 1'b1; ev_n = 0;
    @(negedge clk); btn_clean = 5'b10011;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) btn_clean = '0;
      record(c);
    end
    total++; if (ev_n !== 3) begin bad++; $display("FAIL simul_count: got %0d want 3", ev_n); end
    total++; if (ev_code[0] !== 200) begin bad++; $display("FAIL simul_ev0: got %0d want 200", ev_code[0]); end
    total++; if (ev_code[1] !== 410) begin bad++; $display("FAIL simul_ev1: got %0d want 410", ev_code[1]); end
    total++; if (ev_code[2] !== 640) begin bad++; $display("FAIL simul_ev2: got %0d want 640", ev_code[2]); end
  endtask

  task automatic test_round_robin();
    do_reset(); ev_ready = 1'b0; ev_n = 0;
    @(negedge clk); btn_clean = 5'b00010;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 2) btn_clean = 5'b01011;
      if (c == 3) begin btn_clean = '0; ev_ready = 1'b1; end
      record(c);
    end
    total++; if (ev_n !== 3) begin bad++; $display("FAIL rr_count: got %0d want 3", ev_n); end
    total++; if (ev_code[0] !== 310) begin bad++; $display("FAIL rr_ev0: got %0d want 310", ev_code[0]); end
    total++; if (ev_code[1] !== 530) begin bad++; $display("FAIL rr_ev1: got %0d want 530", ev_code[1]); end
    total++; if (ev_code[2] !== 700) begin bad++; $display("FAIL rr_ev2: got %0d want 700", ev_code[2]); end
  endtask

  task automatic test_long_press();
    do_reset(); ev_ready = 1'b1; ev_n = 0;
    @(negedge clk); btn_clean = 5'b10000;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 12) btn_clean = '0;
      record(c);
    end
    total++; if (ev_n !== 2) begin bad++; $display("FAIL long_count: got %0d want 2", ev_n); end
    total++; if (ev_code[0] !== 240) begin bad++; $display("FAIL long_press_ev: got %0d want 240", ev_code[0]); end
    total++; if (ev_code[1] !== 941) begin bad++; $display("FAIL long_long_ev: got %0d want 941", ev_code[1]); end

    ev_n = 0;
    @(negedge clk); btn_clean = 5'b01000;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 7) btn_clean = '0;
      record(c);
    end
    total++; if (ev_n !== 1) begin bad++; $display("FAIL short7_count: got %0d want 1", ev_n); end
    total++; if (ev_code[0] !== 230) begin bad++; $display("FAIL short7_ev: got %0d want 230", ev_code[0]); end

    ev_n = 0;
    @(negedge clk); btn_clean = 5'b01000;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 8) btn_clean = '0;
      record(c);
    end
    total++; if (ev_n !== 2) begin bad++; $display("FAIL hold8_count: got %0d want 2", ev_n); end
    total++; if (ev_code[0] !== 230) begin bad++; $display("FAIL hold8_press: got %0d want 230", ev_code[0]); end
    total++; if (ev_code[1] !== 931) begin bad++; $display("FAIL hold8_long: got %0d want 931", ev_code[1]); end
  endtask

  task automatic test_backpressure();
    do_reset(); ev_ready = 1'b0; ev_n = 0;
    @(negedge clk); btn_clean = 5'b00010;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      case (c)
        2, 4, 6: btn_clean = '0;
        3, 5:    btn_clean = 5'b00010;
        7:       ev_ready  = 1'b1;
        default: ;
      endcase
      if (c >= 2 && c <= 6) begin
        total++;
        if ({ev_valid, ev_idx, ev_long} !== 5'b10010) begin
          bad++; $display("FAIL offer_hold c=%0d: got v=%b idx=%0d l=%b want v=1 idx=1 l=0", c, ev_valid, ev_idx, ev_long);
        end
      end
      if (c == 4) begin
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_early: got %b want 0", overrun); end
      end
      if (c == 6) begin
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b want 1", overrun); end
      end
      record(c);
    end
    total++; if (ev_n !== 2) begin bad++; $display("FAIL bp_count: got %0d want 2", ev_n); end
    total++; if (ev_code[0] !== 710) begin bad++; $display("FAIL bp_ev0: got %0d want 710", ev_code[0]); end
    total++; if (ev_code[1] !== 910) begin bad++; $display("FAIL bp_ev1: got %0d want 910", ev_code[1]); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_reset_mid();
    ev_ready = 1'b0;
    @(negedge clk); btn_clean = 5'b00100;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 2) btn_clean = 5'b01100;
    end
    total++; if (ev_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b want 1", ev_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", ev_valid); end
    total++; if (overrun !== 1'b0)  begin bad++; $display("FAIL mid_overrun: got %b want 0", overrun); end
    total++; if (ev_idx !== 3'd0)   begin bad++; $display("FAIL mid_idx: got %0d want 0", ev_idx); end
    total++; if (dut.pend !== 5'd0) begin bad++; $display("FAIL mid_pend: got %b want 00000", dut.pend); end
    total++; if (dut.lpend !== 5'd0) begin bad++; $display("FAIL mid_lpend: got %b want 00000", dut.lpend); end
    @(negedge clk); rst = 1'b0; ev_ready = 1'b1; ev_n = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 3) btn_clean = '0;
      record(c);
    end
    total++; if (ev_n !== 2) begin bad++; $display("FAIL mid_count: got %0d want 2", ev_n); end
    total++; if (ev_code[0] !== 220) begin bad++; $display("FAIL mid_ev0: got %0d want 220", ev_code[0]); end
    total++; if (ev_code[1] !== 430) begin bad++; $display("FAIL mid_ev1: got %0d want 430", ev_code[1]); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ev_code[i] = -1;
    ev_n = 0;
    test_reset();
    test_single_press();
    test_simultaneous();
    test_round_robin();
    test_long_press();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
